// File: rtl/sram_mem_controller.sv
// Bridges the MEM stage to an external 16-bit asynchronous SRAM: every 32-bit
// access is split into a low and a high half-word phase of WAIT_CYCLES each.
module sram_mem_controller #(
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_o,
  input  logic [15:0]            sram_dq_i,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n,
  output logic                   sram_oe_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t                 state;
  state_t                 state_next;
  logic [3:0]             cnt;
  logic                   op_wr;
  logic [15:0]            wdata_hi;
  logic                   req;
  logic                   phase_end;
  logic [31:0]            offset;
  logic [SRAM_ADDR_W-1:0] lo_addr;
  logic                   next_in_phase;
  logic                   next_wr;
  logic                   we_n_d;
  logic                   oe_n_d;
  logic                   dq_oe_d;
  logic                   unused_offset_bits;

  assign req       = wr_en | rd_en;
  assign phase_end = (cnt == LAST_CNT);
  assign offset    = address - BASE_ADDR;
  assign lo_addr   = {offset[SRAM_ADDR_W:2], 1'b0};

  assign unused_offset_bits = ^{offset[1:0], offset[31:SRAM_ADDR_W+1]};

  // ready is combinational in IDLE so the core freezes in the request cycle itself
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        ready = ~req;
        if (req) state_next = LO;
      end
      LO:      if (phase_end) state_next = HI;
      HI:      if (phase_end) state_next = DONE;
      DONE: begin
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Strobes are computed for the upcoming state and registered, so they never glitch
  always_comb begin
    next_in_phase = (state_next == LO) || (state_next == HI);
    next_wr       = (state == IDLE) ? wr_en : op_wr;
    we_n_d        = ~(next_in_phase & next_wr);
    oe_n_d        = ~(next_in_phase & ~next_wr);
    dq_oe_d       = next_in_phase & next_wr;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      op_wr      <= 1'b0;
      wdata_hi   <= 16'd0;
      read_data  <= 32'd0;
      sram_addr  <= '0;
      sram_dq_o  <= 16'd0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_dq_oe <= 1'b0;
    end else begin
      state      <= state_next;
      sram_we_n  <= we_n_d;
      sram_oe_n  <= oe_n_d;
      sram_dq_oe <= dq_oe_d;
      case (state)
        IDLE: begin
          if (req) begin
            op_wr     <= wr_en;
            wdata_hi  <= write_data[31:16];
            sram_addr <= lo_addr;
            sram_dq_o <= write_data[15:0];
            cnt       <= 4'd0;
          end
        end
        LO, HI: begin
          if (phase_end) begin
            cnt <= 4'd0;
            if (state == LO) begin
              sram_addr[0] <= 1'b1;
              sram_dq_o    <= wdata_hi;
              if (!op_wr) read_data[15:0] <= sram_dq_i;
            end else if (!op_wr) begin
              read_data[31:16] <= sram_dq_i;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: directed literal cases plus randomized traffic
// checked each cycle against a transaction-level model of the SRAM and the core.
module tb_sram_mem_controller;

  localparam int W  = 2;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [31:0]   address = 32'd0;
  logic [31:0]   write_data = 32'd0;
  logic [31:0]   read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_o;
  logic [15:0]   sram_dq_i;
  logic          sram_dq_oe;
  logic          sram_we_n;
  logic          sram_oe_n;

  logic          wr1 = 1'b0;
  logic          rd1 = 1'b0;
  logic [31:0]   addr1 = 32'd0;
  logic [31:0]   data1 = 32'd0;
  logic [31:0]   read_data1;
  logic          ready1;
  logic [AW-1:0] sram_addr1;
  logic [15:0]   sram_dq_o1;
  logic [15:0]   sram_dq_i1 = 16'hA55A;
  logic          sram_dq_oe1;
  logic          sram_we_n1;
  logic          sram_oe_n1;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sram_mem_controller dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
    .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  sram_mem_controller #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1),
    .address(addr1), .write_data(data1), .read_data(read_data1),
    .ready(ready1), .sram_addr(sram_addr1), .sram_dq_o(sram_dq_o1),
    .sram_dq_i(sram_dq_i1), .sram_dq_oe(sram_dq_oe1),
    .sram_we_n(sram_we_n1), .sram_oe_n(sram_oe_n1)
  );

  function automatic logic [15:0] fill(int i);
    return 16'(i * 4951 + 2571);
  endfunction

  // SRAM device: a half-word is committed only after a full-length write pulse on one address
  logic [15:0]   sram_env [0:63];
  bit            env_init = 1'b0;
  int            wr_run = 0;
  logic [AW-1:0] run_addr = '0;

  always @(posedge clk) begin
    if (!env_init) begin
      for (int i = 0; i < 64; i++) sram_env[i] <= fill(i);
      env_init <= 1'b1;
      wr_run   <= 0;
    end else if (!sram_we_n) begin
      if (wr_run != 0 && sram_addr == run_addr) begin
        wr_run <= wr_run + 1;
        if (wr_run + 1 == W) sram_env[sram_addr[5:0]] <= sram_dq_o;
      end else begin
        wr_run <= 1;
      end
      run_addr <= sram_addr;
    end else begin
      wr_run <= 0;
    end
  end

  assign sram_dq_i = sram_oe_n ? 16'h0000 : sram_env[sram_addr[5:0]];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: k counts cycles since the request was accepted
  bit          m_busy = 1'b0;
  int          m_k = 0;
  bit          m_wr = 1'b0;
  int          m_lo = 0;
  logic [31:0] m_data = 32'd0;
  logic [31:0] exp_rd = 32'd0;
  logic [15:0] mem_m [0:63];

  task automatic modelStep();
    logic [31:0] wi;
    int          idx;
    if (m_busy) begin
      if (m_k == W || m_k == 2 * W) begin
        idx = (m_k == W) ? m_lo : m_lo + 1;
        if (m_wr) mem_m[idx & 63] = (m_k == W) ? m_data[15:0] : m_data[31:16];
        else if (m_k == W) exp_rd[15:0] = mem_m[idx & 63];
        else exp_rd[31:16] = mem_m[idx & 63];
      end
      if (m_k == 2 * W + 1) m_busy = 1'b0;
      else m_k++;
    end else if (wr_en || rd_en) begin
      wi     = (address - 32'd1024) >> 2;
      m_busy = 1'b1;
      m_k    = 1;
      m_wr   = wr_en;
      m_lo   = int'({wi[30:0], 1'b0} & 32'h0003_FFFF);
      m_data = write_data;
    end
    if (!rst) begin
      m_busy = 1'b0;
      exp_rd = 32'd0;
    end
  endtask

  task automatic compareStep();
    bit phase;
    int hw;
    phase = m_busy && m_k <= 2 * W;
    hw    = m_lo + (m_k - 1) / W;
    checkOutput("ready", ready, m_busy ? (m_k == 2 * W + 1) : !(wr_en || rd_en));
    checkOutput("we_n", sram_we_n, !(phase && m_wr));
    checkOutput("oe_n", sram_oe_n, !(phase && !m_wr));
    checkOutput("dq_oe", sram_dq_oe, phase && m_wr);
    checkOutput("read_data", read_data, exp_rd);
    if (phase) checkOutput("sram_addr", sram_addr, hw);
    if (phase && m_wr)
      checkOutput("dq_o", sram_dq_o, (m_k <= W) ? m_data[15:0] : m_data[31:16]);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_m[i] = fill(i);
    forever begin
      @(posedge clk);
      modelStep();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) compareStep();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    wr_en      = w;
    rd_en      = r;
    address    = a;
    write_data = d;
  endtask

  // Directed access with literal expectations for the default two-cycle phases
  task automatic runOp(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                       input int lo_hw, input logic [31:0] exp_word, input string tag);
    applyStimulus(w, r, a, d);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      checkOutput({tag, "_ready"}, ready, k == 5);
      if (k >= 1 && k <= 4) begin
        checkOutput({tag, "_addr"}, sram_addr, lo_hw + ((k > 2) ? 1 : 0));
        if (w) begin
          checkOutput({tag, "_we_n"}, sram_we_n, 0);
          checkOutput({tag, "_dq_o"}, sram_dq_o, (k <= 2) ? exp_word[15:0] : exp_word[31:16]);
        end else begin
          checkOutput({tag, "_oe_n"}, sram_oe_n, 0);
        end
      end
      if (k == 5 && !w) checkOutput({tag, "_rdata"}, read_data, exp_word);
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          w;
    bit          r;
    bit          drop;
    bit          done;
    bit          seen;
    int          sel;
    int          rst_at;
    logic [31:0] a;
    logic [31:0] d;

    applyStimulus(0, 0, 0, 0);
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready", ready, 1);
    checkOutput("rst_we_n", sram_we_n, 1);
    checkOutput("rst_oe_n", sram_oe_n, 1);
    checkOutput("rst_dq_oe", sram_dq_oe, 0);
    checkOutput("rst_rdata", read_data, 32'd0);
    tick();

    runOp(1, 0, 32'd1024, 32'hDEADBEEF, 0, 32'hDEADBEEF, "st0");
    applyStimulus(0, 0, 0, 0);
    tick();
    runOp(0, 1, 32'd1024, 32'd0, 0, 32'hDEADBEEF, "ld0");
    applyStimulus(0, 0, 0, 0);
    tick();
    tick();
    @(negedge clk);
    checkOutput("ld0_hold", read_data, 32'hDEADBEEF);
    tick();

    runOp(1, 0, 32'd1028, 32'h12345678, 2, 32'h12345678, "st1");
    runOp(0, 1, 32'd1028, 32'd0, 2, 32'h12345678, "ld1");
    applyStimulus(0, 0, 0, 0);
    tick();

    applyStimulus(1, 0, 32'd1028, 32'hCAFEF00D);
    tick();
    tick();
    tick();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_ready", ready, 1);
    checkOutput("midrst_we_n", sram_we_n, 1);
    tick();
    runOp(0, 1, 32'd1028, 32'd0, 2, 32'h1234F00D, "ld2");
    applyStimulus(0, 0, 0, 0);
    tick();

    rd1 = 1'b1;
    addr1 = 32'd1024;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      checkOutput("w1ld_ready", ready1, k == 3);
      if (k == 3) checkOutput("w1ld_rdata", read_data1, 32'hA55AA55A);
      tick();
    end
    wr1 = 1'b1;
    rd1 = 1'b1;
    addr1 = 32'd1032;
    data1 = 32'h0BADCAFE;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      checkOutput("w1both_ready", ready1, k == 3);
      if (k >= 1 && k <= 2) begin
        checkOutput("w1both_we_n", sram_we_n1, 0);
        checkOutput("w1both_oe_n", sram_oe_n1, 1);
        checkOutput("w1both_addr", sram_addr1, 3 + k);
        checkOutput("w1both_dq_o", sram_dq_o1, (k == 1) ? 32'h0000CAFE : 32'h00000BAD);
      end
      if (k == 3) checkOutput("w1both_rdata", read_data1, 32'hA55AA55A);
      tick();
    end
    wr1 = 1'b0;
    rd1 = 1'b0;

    for (int n = 0; n < 150; n++) begin
      sel    = $urandom_range(0, 9);
      w      = (sel < 4) || (sel == 9);
      r      = (sel >= 4);
      a      = 32'd1024 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      d      = $urandom;
      drop   = ($urandom_range(0, 9) == 0);
      rst_at = ($urandom_range(0, 14) == 0) ? int'($urandom_range(1, 4)) : -1;
      applyStimulus(w, r, a, d);
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        @(negedge clk);
        seen = (c > 0) && ready;
        tick();
        if (seen) begin
          done = 1'b1;
        end else if (c == rst_at) begin
          rst = 1'b0;
          applyStimulus(0, 0, 0, 0);
          tick();
          rst = 1'b1;
          done = 1'b1;
        end else if (c == 0 && drop) begin
          applyStimulus(0, 0, a, d);
        end
      end
      checkOutput("op_done", done, 1);
      applyStimulus(0, 0, 0, 0);
      repeat ($urandom_range(0, 2)) tick();
    end

    tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Sits directly downstream of the pipeline's MEM stage. It replaces the on-chip data array with an external 16-bit asynchronous SRAM.
- Each 32-bit load or store becomes two 16-bit SRAM accesses, low half first, with programmable wait states.
- Drives `ready` low while an access is in flight. The core ORs `~ready` into its freeze so the IF, ID, EXE and MEM registers hold until `ready` returns high.

Parameters:
- SRAM_ADDR_W, 18, SRAM half-word address width.
- WAIT_CYCLES, 2, cycles each half-word phase lasts (legal range 1..15).
- BASE_ADDR, 1024, byte address mapped to SRAM half-word 0. It is subtracted before translation.

Ports:
- clk  in  1  single clock. All state updates on the rising edge.
- rst  in  1  synchronous reset, active-low (rst=0 at a rising edge resets).
- wr_en  in  1  store request from MEM stage, held while ready=0.
- rd_en  in  1  load request from MEM stage, held while ready=0.
- address  in  32  byte address (ALU result). Bits [1:0] are ignored.
- write_data  in  32  store value (Val_Rm).
- read_data  out  32  load result, valid in the DONE cycle.
- ready  out  1  high when no access is pending. The core freezes while it is low.
- sram_addr  out  SRAM_ADDR_W  SRAM half-word address.
- sram_dq_o  out  16  write data to the SRAM.
- sram_dq_i  in  16  read data from the SRAM.
- sram_dq_oe  out  1  data-bus drive enable.
- sram_we_n  out  1  SRAM write strobe, active-low.
- sram_oe_n  out  1  SRAM output enable, active-low.

Behaviour:
- Address translation: widx = (address - BASE_ADDR) >> 2, 32-bit unsigned with wrap.
  - Low-half address = {widx, 1'b0}; high-half address = {widx, 1'b1}. Both truncated to SRAM_ADDR_W.
  - Low half = data[15:0]; high half = data[31:16].
- FSM states: IDLE, LO, HI, DONE. Phase counter cnt is 4 bits.
- IDLE:
  - If wr_en|rd_en, latch op (write if wr_en, which wins when both are high), address and write_data.
  - Set cnt=0 and go to LO.
  - ready = ~(wr_en|rd_en), combinational, so the freeze applies in the request cycle.
- LO, and HI identically:
  - Hold sram_addr for the phase; cnt increments each cycle.
  - Write: sram_we_n=0, sram_dq_oe=1, sram_dq_o = the phase's half, sram_oe_n=1.
  - Read: sram_oe_n=0, sram_we_n=1, sram_dq_oe=0. Capture sram_dq_i into the phase's half of read_data on the last cycle (cnt==WAIT_CYCLES-1).
  - When cnt==WAIT_CYCLES-1, reset cnt and advance (LO to HI, HI to DONE). ready=0.
- DONE: ready=1 for exactly one cycle, strobes inactive, read_data holds the full word. Next state is IDLE unconditionally, so there is no re-trigger on the held request.
- Latency: the request is seen in cycle 0, ready=0 in cycles 0..2*WAIT_CYCLES, and ready=1 in cycle 2*WAIT_CYCLES+1. With the default that is 5 stall cycles.
- The pipeline advances on the DONE edge. A new request in the following IDLE cycle starts immediately, with no dead cycle beyond DONE.
- If wr_en/rd_en drop mid-operation, the latched op still completes; the inputs are not re-sampled until IDLE.
- read_data keeps its last load value across stores and idle periods.
- Outputs idle when not in a phase: sram_we_n=1, sram_oe_n=1, sram_dq_oe=0.
- Reset (any state, including mid-phase): state=IDLE, cnt=0, read_data=0, sram_addr=0, sram_dq_o=0, sram_we_n=1, sram_oe_n=1, sram_dq_oe=0. ready=1 when no request is present.
- Strobes must be glitch-free registered outputs or decoded directly from state; sram_we_n must never be low in IDLE or DONE.

Test Plan:
- Reset with rst=0 for 2 cycles, no requests -> ready=1, sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, read_data=0.
- Store 0xDEADBEEF to address 1024 -> sram_addr=0 with dq_o=0xBEEF and we_n=0 for 2 cycles, then sram_addr=1 with 0xDEAD for 2 cycles. ready=0 for 5 cycles, then 1 for one cycle.
- Load from 1024 with the SRAM model from the previous step -> oe_n=0 on addresses 0 then 1; read_data=0xDEADBEEF in the DONE cycle and held afterwards.
- Back-to-back: store 0x12345678 to 1028, then load from 1028 on the cycle after DONE -> sram addresses 2 and 3 are used. Load returns 0x12345678 with no extra idle cycle between operations.
- rst=0 during the HI phase of a store -> next cycle IDLE, we_n=1, ready=1. Half-word 3 is not written, and a later load of 1028 shows the stale high half.
- wr_en=rd_en=1 to address 1032 with WAIT_CYCLES=1 -> the write is performed, ready=0 for 3 cycles, and read_data is unchanged.
